descrambler_block_lock: RTL
===========================

// Module: descrambler_block_lock
// PURPOSE
//  Receive-side partner of the 64b/66b transmit scrambler: takes aligned 66-bit blocks, acquires block lock on the 2-bit sync header, and self-synchronously descrambles the 64-bit payload (x^58+x^39+1).
//  Sits between the RX gearbox, which receives its slip requests, and the PCS decoder / pattern checker.
// PARAMETERS
//  LOCK_CNT   64  consecutive valid headers required to gain lock; also the monitor window length while locked
//  INVLD_MAX  16  invalid headers within one LOCK_CNT window that drop lock
//  SLIP_WAIT  2   rx_valid words ignored after a slip, while the gearbox realigns
// PORTS
//  CLK               in   1   clock; all logic on posedge
//  reset             in   1   asynchronous, active-high reset
//  rx_valid          in   1   rx_block is valid this cycle
//  rx_block          in   66  [65:64] sync header, [63:0] scrambled payload (bit 0 first)
//  slip              out  1   one-cycle pulse: gearbox shifts alignment by one bit
//  block_lock        out  1   block lock achieved
//  data_valid        out  1   data_descrambled/sync_hdr valid
//  data_descrambled  out  64  descrambled payload
//  sync_hdr          out  2   header of the same block, registered
//  err_cnt_clr       in   1   clear hdr_err_cnt (macro only)
//  hdr_err_cnt       out  16  saturating invalid-header count (macro only)
// BEHAVIOUR
//  - Reset: every output 0, prev state 0, FSM LOCK_INIT, all counters 0.
//  - Valid header: 2'b01 or 2'b10. Invalid: 2'b00 or 2'b11. Only rx_valid cycles count.
//  - Descrambler: prev[57:0] <= rx_block[63:6] on every rx_valid (lock state irrelevant). With s = rx_block[63:0]:
//     i in 0..38:  out[i] = s[i] ^ prev[i+19] ^ prev[i]
//     i in 39..57: out[i] = s[i] ^ s[i-39] ^ prev[i]
//     i in 58..63: out[i] = s[i] ^ s[i-39] ^ s[i-58]
//  - Latency: 1 cycle. data_valid(t+1) = rx_valid(t) & block_lock(t). data_descrambled/sync_hdr hold value when data_valid is 0.
//  - FSM states: LOCK_INIT, TEST_SH, SLIP, GOOD.
//     LOCK_INIT -> TEST_SH after reset; sh_cnt=0, invld_cnt=0, block_lock=0.
//     TEST_SH (unlocked): valid header -> sh_cnt++. sh_cnt reaches LOCK_CNT -> GOOD, block_lock=1, counters cleared.
//       Invalid header -> SLIP.
//     SLIP: slip=1 for exactly one cycle, counters cleared. Discard the next SLIP_WAIT rx_valid words uncounted, then TEST_SH.
//     GOOD: count headers per window (sh_cnt) and invalid headers (invld_cnt).
//       invld_cnt reaches INVLD_MAX -> block_lock=0 next cycle, then SLIP.
//       sh_cnt reaches LOCK_CNT with invld_cnt<INVLD_MAX -> both counters cleared, stay GOOD.
//       Both on the same word -> loss of lock wins.
//  - Counters: sh_cnt width $clog2(LOCK_CNT+1); invld_cnt width $clog2(INVLD_MAX+1); no wrap.
//  - Slip never asserts on consecutive cycles. Reset during SLIP wait aborts the wait and returns to LOCK_INIT.
// CONFIGURATION
//  SH_ERR_CNT_EN defined: hdr_err_cnt counts every invalid header on rx_valid, locked or not, and saturates at 16'hFFFF.
//    err_cnt_clr sets it to 0. A clear and an error in the same cycle yields 1.
//  SH_ERR_CNT_EN undefined: err_cnt_clr and hdr_err_cnt are not present; no counter logic.
// TESTING
//  1 reset mid-traffic -> all outputs 0 next edge, block_lock=0, FSM restarts lock acquisition.
//  2 64 valid headers back-to-back -> block_lock=1 the cycle after the 64th; no slip.
//  3 unlocked, invalid header (2'b11) at word 10 -> slip=1 for one cycle.
//    Next 2 words ignored; then 64 valid headers -> lock.
//  4 locked, 15 invalid in a 64-word window -> lock held.
//    16 invalid in a window -> block_lock=0, one slip pulse.
//  5 drive scrambler output (reset seed 0) for payload sequence 64'h0123456789ABCDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF with header 2'b01 ->
//    after lock, data_descrambled equals the original payload, 1-cycle latency.
//  6 SH_ERR_CNT_EN: 3 invalid headers -> hdr_err_cnt=3; err_cnt_clr together with an error -> hdr_err_cnt=1; forced to 16'hFFFF it stays there.

Source files
------------

// File: rtl/descrambler_block_lock_if.sv
// rtl/descrambler_block_lock_if.sv - block stream and status bundle for descrambler_block_lock
// Signals:
//   rx_valid, rx_block[65:0]         aligned block from the gearbox ([65:64] sync header)
//   slip                             one-cycle alignment shift request to the gearbox
//   block_lock                       block lock status
//   data_valid, data_descrambled, sync_hdr   registered descrambled block
//   err_cnt_clr, hdr_err_cnt         invalid-header counter, present only with SH_ERR_CNT_EN
// master = block source / status sink, slave = descrambler.
interface descrambler_block_lock_if;
    logic        rx_valid;
    logic [65:0] rx_block;
    logic        slip;
    logic        block_lock;
    logic        data_valid;
    logic [63:0] data_descrambled;
    logic [1:0]  sync_hdr;
`ifdef SH_ERR_CNT_EN
    logic        err_cnt_clr;
    logic [15:0] hdr_err_cnt;

    modport master (
        output rx_valid, rx_block, err_cnt_clr,
        input  slip, block_lock, data_valid, data_descrambled, sync_hdr, hdr_err_cnt
    );
    modport slave (
        input  rx_valid, rx_block, err_cnt_clr,
        output slip, block_lock, data_valid, data_descrambled, sync_hdr, hdr_err_cnt
    );
`else
    modport master (
        output rx_valid, rx_block,
        input  slip, block_lock, data_valid, data_descrambled, sync_hdr
    );
    modport slave (
        input  rx_valid, rx_block,
        output slip, block_lock, data_valid, data_descrambled, sync_hdr
    );
`endif
endinterface

// File: rtl/descrambler_block_lock.sv
// rtl/descrambler_block_lock.sv - 64b/66b block lock FSM and x^58+x^39+1 self-synchronous descrambler
// Purpose: acquires block lock on the 2-bit sync header, requests gearbox slips while
//          unlocked, and descrambles the 64-bit payload with one cycle of latency.
// Ports:   CLK    clock, posedge
//          reset  asynchronous, active high
//          bus    descrambler_block_lock_if.slave (rx block in, slip/lock/descrambled block out)
// Config:  define SH_ERR_CNT_EN to add the saturating invalid-header counter
//          (bus.err_cnt_clr / bus.hdr_err_cnt).
module descrambler_block_lock #(
    parameter int LOCK_CNT  = 64,
    parameter int INVLD_MAX = 16,
    parameter int SLIP_WAIT = 2
) (
    input logic                     CLK,
    input logic                     reset,
    descrambler_block_lock_if.slave bus
);
    localparam int SH_W = $clog2(LOCK_CNT + 1);
    localparam int IV_W = $clog2(INVLD_MAX + 1);
    localparam int WT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(LOCK_CNT);
    localparam logic [IV_W-1:0] IV_LAST = IV_W'(INVLD_MAX);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(SLIP_WAIT);

    typedef enum logic [1:0] {LOCK_INIT, TEST_SH, SLIP, GOOD} state_t;

    state_t          state_q, state_d;
    logic [SH_W-1:0] sh_cnt_q, sh_cnt_d, sh_inc;
    logic [IV_W-1:0] invld_cnt_q, invld_cnt_d, invld_inc;
    logic [WT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic            block_lock_q, block_lock_d;
    logic            slip_q, slip_d;
    logic [57:0]     prev_q, prev_d;
    logic            data_valid_q, data_valid_d;
    logic [63:0]     data_q, data_d;
    logic [1:0]      hdr_q, hdr_d;
    logic [63:0]     desc;
    logic [121:0]    hist;
    logic            hdr_ok;

    // 01 and 10 are the only legal sync headers
    assign hdr_ok = bus.rx_block[65] ^ bus.rx_block[64];

    // hist[58+i] is current bit i, hist[j<58] the previous block's last 58 bits,
    // so each output bit taps the received stream 39 and 58 bits back.
    always_comb begin
        hist = {bus.rx_block[63:0], prev_q};
        desc = '0;
        for (int i = 0; i < 64; i++) begin
            desc[i] = hist[i+58] ^ hist[i+19] ^ hist[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        invld_cnt_d  = invld_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        block_lock_d = block_lock_q;
        slip_d       = 1'b0;
        sh_inc       = sh_cnt_q + SH_W'(1);
        invld_inc    = invld_cnt_q + IV_W'(1);
        wait_inc     = wait_cnt_q + WT_W'(1);
        case (state_q)
            LOCK_INIT: begin
                sh_cnt_d     = '0;
                invld_cnt_d  = '0;
                wait_cnt_d   = '0;
                block_lock_d = 1'b0;
                state_d      = TEST_SH;
            end
            TEST_SH: begin
                if (bus.rx_valid) begin
                    if (!hdr_ok) begin
                        state_d     = SLIP;
                        slip_d      = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        wait_cnt_d  = '0;
                    end else if (sh_inc == SH_LAST) begin
                        state_d      = GOOD;
                        block_lock_d = 1'b1;
                        sh_cnt_d     = '0;
                        invld_cnt_d  = '0;
                    end else begin
                        sh_cnt_d = sh_inc;
                    end
                end
            end
            SLIP: begin
                // words arriving while the gearbox realigns are dropped uncounted
                if (SLIP_WAIT == 0) begin
                    state_d = TEST_SH;
                end else if (bus.rx_valid) begin
                    if (wait_inc == WT_LAST) begin
                        state_d    = TEST_SH;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_inc;
                    end
                end
            end
            GOOD: begin
                if (bus.rx_valid) begin
                    // loss of lock takes priority over a window wrap on the same word
                    if (!hdr_ok && invld_inc == IV_LAST) begin
                        state_d      = SLIP;
                        slip_d       = 1'b1;
                        block_lock_d = 1'b0;
                        sh_cnt_d     = '0;
                        invld_cnt_d  = '0;
                        wait_cnt_d   = '0;
                    end else if (sh_inc == SH_LAST) begin
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_inc;
                        if (!hdr_ok) invld_cnt_d = invld_inc;
                    end
                end
            end
            default: state_d = LOCK_INIT;
        endcase
    end

    always_comb begin
        prev_d       = bus.rx_valid ? bus.rx_block[63:6] : prev_q;
        data_valid_d = bus.rx_valid & block_lock_q;
        data_d       = data_valid_d ? desc : data_q;
        hdr_d        = data_valid_d ? bus.rx_block[65:64] : hdr_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= LOCK_INIT;
            sh_cnt_q     <= '0;
            invld_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            slip_q       <= 1'b0;
            prev_q       <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            hdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            invld_cnt_q  <= invld_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_q <= block_lock_d;
            slip_q       <= slip_d;
            prev_q       <= prev_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            hdr_q        <= hdr_d;
        end
    end

    assign bus.slip             = slip_q;
    assign bus.block_lock       = block_lock_q;
    assign bus.data_valid       = data_valid_q;
    assign bus.data_descrambled = data_q;
    assign bus.sync_hdr         = hdr_q;

`ifdef SH_ERR_CNT_EN
    logic [15:0] hdr_err_cnt_q, hdr_err_cnt_d;
    logic        hdr_err;

    assign hdr_err = bus.rx_valid & ~hdr_ok;

    // a clear coinciding with an error leaves that error counted
    always_comb begin
        hdr_err_cnt_d = hdr_err_cnt_q;
        if (bus.err_cnt_clr) begin
            hdr_err_cnt_d = {15'd0, hdr_err};
        end else if (hdr_err && hdr_err_cnt_q != 16'hFFFF) begin
            hdr_err_cnt_d = hdr_err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) hdr_err_cnt_q <= '0;
        else       hdr_err_cnt_q <= hdr_err_cnt_d;
    end

    assign bus.hdr_err_cnt = hdr_err_cnt_q;
`endif
endmodule
